// File: rtl/axi_to_axi_lite_conv_if.sv
// AXI4 (AXI_BUS) and AXI4-Lite (AXI_LITE) bus bundles used by axi_to_axi_lite_conv.
// Master/Slave modports are declared from the point of view of each bus end.

interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot, aw_qos,
           aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot, ar_qos,
           ar_region, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

interface AXI_LITE #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64
);
  localparam int unsigned AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8;

  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [2:0]                aw_prot;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [AXI_STRB_WIDTH-1:0] w_strb;
  logic                      w_valid;
  logic                      w_ready;

  logic [1:0]                b_resp;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [2:0]                ar_prot;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_addr, aw_prot, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_valid,
    input  w_ready,
    input  b_resp, b_valid,
    output b_ready,
    output ar_addr, ar_prot, ar_valid,
    input  ar_ready,
    input  r_data, r_resp, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_addr, aw_prot, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_valid,
    output w_ready,
    output b_resp, b_valid,
    input  b_ready,
    input  ar_addr, ar_prot, ar_valid,
    output ar_ready,
    output r_data, r_resp, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/axi_to_axi_lite_conv.sv
// AXI4 slave to AXI4-Lite master bridge: bursts become single-beat Lite transfers.
// Define AXI_TO_LITE_WRAP_EN to convert WRAP bursts; otherwise they are answered with SLVERR.

module axi_to_axi_lite_conv #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  AXI_BUS.Slave    slv,
  AXI_LITE.Master  mst
);

  localparam int unsigned AW       = AXI_ADDR_WIDTH;
  localparam int unsigned MaxSize  = $clog2(AXI_DATA_WIDTH / 8);
  localparam logic [1:0]  RespOkay = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  typedef enum logic [2:0] {WIdle, WReq, WResp, WBResp, WDrain} w_state_e;
  typedef enum logic [1:0] {RIdle, RReq, RData, RErr} r_state_e;

  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] addr, input logic [7:0] len,
                                              input logic [2:0] size, input logic [1:0] burst,
                                              input logic [7:0] cnt);
    logic [AW-1:0] offs;
`ifdef AXI_TO_LITE_WRAP_EN
    logic [AW-1:0] mask;
    mask = ((AW'(len) + AW'(1)) << size) - AW'(1);
`else
    logic unused_len;
    unused_len = ^len;
`endif
    offs = AW'(cnt) << size;
    unique case (burst)
      2'b00:   beat_addr = addr;
`ifdef AXI_TO_LITE_WRAP_EN
      2'b10:   beat_addr = (addr & ~mask) | ((addr + offs) & mask);
`endif
      default: beat_addr = addr + offs;
    endcase
  endfunction

  function automatic logic bad_burst(input logic [2:0] size, input logic [1:0] burst);
    logic bad;
    bad = (size > 3'(MaxSize)) || (burst == 2'b11);
`ifndef AXI_TO_LITE_WRAP_EN
    bad = bad || (burst == 2'b10);
`endif
    return bad;
  endfunction

  // ---------------------------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------------------------
  w_state_e                w_state_q, w_state_d;
  logic [AXI_ID_WIDTH-1:0] w_id_q, w_id_d;
  logic [AW-1:0]           w_addr_q, w_addr_d;
  logic [7:0]              w_len_q, w_len_d;
  logic [2:0]              w_size_q, w_size_d;
  logic [1:0]              w_burst_q, w_burst_d;
  logic [2:0]              w_prot_q, w_prot_d;
  logic [7:0]              w_cnt_q, w_cnt_d;
  logic [1:0]              w_resp_q, w_resp_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_addr_d  = w_addr_q;
    w_len_d   = w_len_q;
    w_size_d  = w_size_q;
    w_burst_d = w_burst_q;
    w_prot_d  = w_prot_q;
    w_cnt_d   = w_cnt_q;
    w_resp_d  = w_resp_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    slv.aw_ready = 1'b0;
    slv.w_ready  = 1'b0;
    slv.b_valid  = 1'b0;
    slv.b_id     = w_id_q;
    slv.b_resp   = w_resp_q;
    slv.b_user   = '0;
    mst.aw_valid = 1'b0;
    mst.aw_addr  = beat_addr(w_addr_q, w_len_q, w_size_q, w_burst_q, w_cnt_q);
    mst.aw_prot  = w_prot_q;
    mst.w_valid  = 1'b0;
    mst.w_data   = slv.w_data;
    mst.w_strb   = slv.w_strb;
    mst.b_ready  = 1'b0;

    unique case (w_state_q)
      WIdle: begin
        // Hold off acceptance while reset is asserted so no request is taken mid-reset.
        slv.aw_ready = rst_ni;
        if (slv.aw_valid) begin
          w_id_d    = slv.aw_id;
          w_addr_d  = slv.aw_addr;
          w_len_d   = slv.aw_len;
          w_size_d  = slv.aw_size;
          w_burst_d = slv.aw_burst;
          w_prot_d  = slv.aw_prot;
          w_cnt_d   = '0;
          w_resp_d  = RespOkay;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = ((slv.aw_atop != '0) || bad_burst(slv.aw_size, slv.aw_burst)) ?
                      WDrain : WReq;
        end
      end
      WReq: begin
        mst.aw_valid = !aw_done_q;
        mst.w_valid  = slv.w_valid && !w_done_q;
        slv.w_ready  = mst.w_ready && !w_done_q;
        aw_done_d    = aw_done_q || mst.aw_ready;
        w_done_d     = w_done_q || (slv.w_valid && mst.w_ready);
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          w_state_d = WResp;
        end
      end
      WResp: begin
        mst.b_ready = 1'b1;
        if (mst.b_valid) begin
          // Response codes are ordered by severity, so the numeric max is the worst one.
          w_resp_d = (mst.b_resp > w_resp_q) ? mst.b_resp : w_resp_q;
          if (w_cnt_q == w_len_q) begin
            w_state_d = WBResp;
          end else begin
            w_cnt_d   = w_cnt_q + 8'd1;
            w_state_d = WReq;
          end
        end
      end
      WBResp: begin
        slv.b_valid = 1'b1;
        if (slv.b_ready) w_state_d = WIdle;
      end
      WDrain: begin
        slv.w_ready = 1'b1;
        if (slv.w_valid) begin
          if (w_cnt_q == w_len_q) begin
            w_resp_d  = RespSlvErr;
            w_state_d = WBResp;
          end else begin
            w_cnt_d = w_cnt_q + 8'd1;
          end
        end
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      w_state_q <= WIdle;
      w_id_q    <= '0;
      w_addr_q  <= '0;
      w_len_q   <= '0;
      w_size_q  <= '0;
      w_burst_q <= '0;
      w_prot_q  <= '0;
      w_cnt_q   <= '0;
      w_resp_q  <= RespOkay;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_addr_q  <= w_addr_d;
      w_len_q   <= w_len_d;
      w_size_q  <= w_size_d;
      w_burst_q <= w_burst_d;
      w_prot_q  <= w_prot_d;
      w_cnt_q   <= w_cnt_d;
      w_resp_q  <= w_resp_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------------------------
  r_state_e                r_state_q, r_state_d;
  logic [AXI_ID_WIDTH-1:0] r_id_q, r_id_d;
  logic [AW-1:0]           r_addr_q, r_addr_d;
  logic [7:0]              r_len_q, r_len_d;
  logic [2:0]              r_size_q, r_size_d;
  logic [1:0]              r_burst_q, r_burst_d;
  logic [2:0]              r_prot_q, r_prot_d;
  logic [7:0]              r_cnt_q, r_cnt_d;
  logic                    r_is_last;

  assign r_is_last = (r_cnt_q == r_len_q);

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_addr_d  = r_addr_q;
    r_len_d   = r_len_q;
    r_size_d  = r_size_q;
    r_burst_d = r_burst_q;
    r_prot_d  = r_prot_q;
    r_cnt_d   = r_cnt_q;

    slv.ar_ready = 1'b0;
    slv.r_valid  = 1'b0;
    slv.r_id     = r_id_q;
    slv.r_data   = '0;
    slv.r_resp   = RespOkay;
    slv.r_last   = r_is_last;
    slv.r_user   = '0;
    mst.ar_valid = 1'b0;
    mst.ar_addr  = beat_addr(r_addr_q, r_len_q, r_size_q, r_burst_q, r_cnt_q);
    mst.ar_prot  = r_prot_q;
    mst.r_ready  = 1'b0;

    unique case (r_state_q)
      RIdle: begin
        slv.ar_ready = rst_ni;
        if (slv.ar_valid) begin
          r_id_d    = slv.ar_id;
          r_addr_d  = slv.ar_addr;
          r_len_d   = slv.ar_len;
          r_size_d  = slv.ar_size;
          r_burst_d = slv.ar_burst;
          r_prot_d  = slv.ar_prot;
          r_cnt_d   = '0;
          r_state_d = bad_burst(slv.ar_size, slv.ar_burst) ? RErr : RReq;
        end
      end
      RReq: begin
        mst.ar_valid = 1'b1;
        if (mst.ar_ready) r_state_d = RData;
      end
      RData: begin
        slv.r_valid = mst.r_valid;
        slv.r_data  = mst.r_data;
        slv.r_resp  = mst.r_resp;
        mst.r_ready = slv.r_ready;
        if (mst.r_valid && slv.r_ready) begin
          if (r_is_last) begin
            r_state_d = RIdle;
          end else begin
            r_cnt_d   = r_cnt_q + 8'd1;
            r_state_d = RReq;
          end
        end
      end
      RErr: begin
        slv.r_valid = 1'b1;
        slv.r_resp  = RespSlvErr;
        if (slv.r_ready) begin
          if (r_is_last) r_state_d = RIdle;
          else           r_cnt_d   = r_cnt_q + 8'd1;
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state_q <= RIdle;
      r_id_q    <= '0;
      r_addr_q  <= '0;
      r_len_q   <= '0;
      r_size_q  <= '0;
      r_burst_q <= '0;
      r_prot_q  <= '0;
      r_cnt_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_addr_q  <= r_addr_d;
      r_len_q   <= r_len_d;
      r_size_q  <= r_size_d;
      r_burst_q <= r_burst_d;
      r_prot_q  <= r_prot_d;
      r_cnt_q   <= r_cnt_d;
    end
  end

  // Sideband fields with no AXI-Lite equivalent; beat counting relies on len, not w_last.
  logic unused_sideband;
  assign unused_sideband = ^{slv.aw_lock, slv.aw_cache, slv.aw_qos, slv.aw_region, slv.aw_user,
                             slv.w_last, slv.w_user, slv.ar_lock, slv.ar_cache, slv.ar_qos,
                             slv.ar_region, slv.ar_user};

endmodule

// File: tb/tb_axi_to_axi_lite_conv.sv
// Self-checking bench for axi_to_axi_lite_conv: vector table driven through a scoreboard,
// plus a backpressure-then-reset sequence.

module tb_axi_to_axi_lite_conv;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 4;
  localparam int unsigned UW = 1;
`ifdef AXI_TO_LITE_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  AXI_BUS #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW),
            .AXI_USER_WIDTH(UW)) slv_bus ();
  AXI_LITE #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) lite_bus ();

  axi_to_axi_lite_conv #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW), .AXI_USER_WIDTH(UW)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .slv    (slv_bus),
    .mst    (lite_bus)
  );

  typedef struct {
    bit          is_wr;
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [5:0]  atop;
    logic [7:0]  lite_b;     // per-beat Lite B responses, 2 bits per beat
    bit          exp_err;
    logic [1:0]  exp_bresp;
  } vec_t;

  typedef struct { logic [63:0] data; logic [7:0] strb; } wbeat_t;
  typedef struct { logic [3:0] id; logic [1:0] resp; } bexp_t;
  typedef struct { logic [3:0] id; logic [63:0] data; logic [1:0] resp; bit last; } rexp_t;

  vec_t        aw_q[$], ar_q[$];
  wbeat_t      w_q[$], exp_lw[$];
  bexp_t       exp_b[$];
  rexp_t       exp_r[$];
  logic [63:0] exp_law[$], exp_lar[$];
  logic [1:0]  lite_bq[$];
  logic [2:0]  exp_aw_prot, exp_ar_prot;

  int n_checks = 0;
  int n_fail = 0;

  bit f_aw, f_w, f_b, f_ar, f_r, f_law, f_lw, f_lb, f_lar, f_lr;
  bit l_aw_got, l_w_got, l_r_pend, stall_w;
  logic [63:0] l_ar_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event not expected / not seen in time", name);
  endtask

  function automatic logic [63:0] rdata_model(input logic [63:0] a);
    return {a[31:0] ^ 32'hDEAD_BEEF, a[31:0]};
  endfunction

  // Walks the burst beat by beat rather than computing the offset directly.
  function automatic logic [63:0] model_addr(input vec_t v, input int i);
    logic [63:0] a, step, win, lo;
    a    = v.addr;
    step = 64'd1 << v.size;
    win  = (64'(v.len) + 64'd1) << v.size;
    lo   = v.addr - (v.addr % win);
    for (int k = 0; k < i; k++) begin
      if (v.burst == 2'b01) a = a + step;
      else if (v.burst == 2'b10) begin
        a = a + step;
        if (a >= lo + win) a = a - win;
      end
    end
    return a;
  endfunction

  // Drive phase on the falling edge, sample phase 2 time units later; handshakes seen in the
  // sample phase complete on the following rising edge.
  initial begin
    slv_bus.aw_valid = 0; slv_bus.w_valid = 0; slv_bus.ar_valid = 0;
    slv_bus.b_ready = 0;  slv_bus.r_ready = 0;
    slv_bus.aw_id = 0; slv_bus.aw_addr = 0; slv_bus.aw_len = 0; slv_bus.aw_size = 0;
    slv_bus.aw_burst = 0; slv_bus.aw_lock = 0; slv_bus.aw_cache = 0; slv_bus.aw_prot = 0;
    slv_bus.aw_qos = 0; slv_bus.aw_region = 0; slv_bus.aw_atop = 0; slv_bus.aw_user = 0;
    slv_bus.w_data = 0; slv_bus.w_strb = 0; slv_bus.w_last = 0; slv_bus.w_user = 0;
    slv_bus.ar_id = 0; slv_bus.ar_addr = 0; slv_bus.ar_len = 0; slv_bus.ar_size = 0;
    slv_bus.ar_burst = 0; slv_bus.ar_lock = 0; slv_bus.ar_cache = 0; slv_bus.ar_prot = 0;
    slv_bus.ar_qos = 0; slv_bus.ar_region = 0; slv_bus.ar_user = 0;
    lite_bus.aw_ready = 0; lite_bus.w_ready = 0; lite_bus.ar_ready = 0;
    lite_bus.b_valid = 0; lite_bus.b_resp = 0;
    lite_bus.r_valid = 0; lite_bus.r_data = 0; lite_bus.r_resp = 0;
    forever begin
      @(negedge clk);
      if (f_aw) slv_bus.aw_valid = 0;
      if (!slv_bus.aw_valid && aw_q.size() > 0) begin
        vec_t v;
        v = aw_q.pop_front();
        slv_bus.aw_id = v.id; slv_bus.aw_addr = v.addr; slv_bus.aw_len = v.len;
        slv_bus.aw_size = v.size; slv_bus.aw_burst = v.burst; slv_bus.aw_atop = v.atop;
        slv_bus.aw_prot = v.id[2:0]; exp_aw_prot = v.id[2:0];
        slv_bus.aw_valid = 1;
      end
      if (f_w) slv_bus.w_valid = 0;
      if (!slv_bus.w_valid && w_q.size() > 0) begin
        wbeat_t wb;
        wb = w_q.pop_front();
        slv_bus.w_data = wb.data; slv_bus.w_strb = wb.strb;
        slv_bus.w_last = (w_q.size() == 0);
        slv_bus.w_valid = 1;
      end
      if (f_ar) slv_bus.ar_valid = 0;
      if (!slv_bus.ar_valid && ar_q.size() > 0) begin
        vec_t v;
        v = ar_q.pop_front();
        slv_bus.ar_id = v.id; slv_bus.ar_addr = v.addr; slv_bus.ar_len = v.len;
        slv_bus.ar_size = v.size; slv_bus.ar_burst = v.burst;
        slv_bus.ar_prot = v.id[2:0]; exp_ar_prot = v.id[2:0];
        slv_bus.ar_valid = 1;
      end
      slv_bus.b_ready = ($urandom_range(0, 3) != 0);
      slv_bus.r_ready = ($urandom_range(0, 3) != 0);
      // Lite slave model: one B after its AW and W, one R per AR.
      if (f_lb) begin lite_bus.b_valid = 0; l_aw_got = 0; l_w_got = 0; end
      if (f_law) l_aw_got = 1;
      if (f_lw) l_w_got = 1;
      if (l_aw_got && l_w_got && !lite_bus.b_valid) begin
        lite_bus.b_resp = (lite_bq.size() > 0) ? lite_bq.pop_front() : 2'b00;
        lite_bus.b_valid = 1;
      end
      if (f_lr) lite_bus.r_valid = 0;
      if (f_lar) l_r_pend = 1;
      if (l_r_pend && !lite_bus.r_valid) begin
        lite_bus.r_data = rdata_model(l_ar_addr);
        lite_bus.r_resp = {1'b0, l_ar_addr[3]};
        lite_bus.r_valid = 1;
        l_r_pend = 0;
      end
      lite_bus.aw_ready = ($urandom_range(0, 3) != 0);
      lite_bus.ar_ready = ($urandom_range(0, 3) != 0);
      lite_bus.w_ready  = stall_w ? 1'b0 : ($urandom_range(0, 3) != 0);
      #2;
      f_aw  = slv_bus.aw_valid && slv_bus.aw_ready;
      f_w   = slv_bus.w_valid && slv_bus.w_ready;
      f_b   = slv_bus.b_valid && slv_bus.b_ready;
      f_ar  = slv_bus.ar_valid && slv_bus.ar_ready;
      f_r   = slv_bus.r_valid && slv_bus.r_ready;
      f_law = lite_bus.aw_valid && lite_bus.aw_ready;
      f_lw  = lite_bus.w_valid && lite_bus.w_ready;
      f_lb  = lite_bus.b_valid && lite_bus.b_ready;
      f_lar = lite_bus.ar_valid && lite_bus.ar_ready;
      f_lr  = lite_bus.r_valid && lite_bus.r_ready;
      if (f_b) begin
        if (exp_b.size() == 0) fail_now("slv_b_unexpected");
        else begin
          bexp_t e;
          e = exp_b.pop_front();
          check("slv_b_id", 64'(slv_bus.b_id), 64'(e.id));
          check("slv_b_resp", 64'(slv_bus.b_resp), 64'(e.resp));
          check("slv_b_user", 64'(slv_bus.b_user), 64'd0);
        end
      end
      if (f_r) begin
        if (exp_r.size() == 0) fail_now("slv_r_unexpected");
        else begin
          rexp_t e;
          e = exp_r.pop_front();
          check("slv_r_id", 64'(slv_bus.r_id), 64'(e.id));
          check("slv_r_data", slv_bus.r_data, e.data);
          check("slv_r_resp", 64'(slv_bus.r_resp), 64'(e.resp));
          check("slv_r_last", 64'(slv_bus.r_last), 64'(e.last));
        end
      end
      if (f_law) begin
        if (exp_law.size() == 0) fail_now("lite_aw_unexpected");
        else begin
          check("lite_aw_addr", lite_bus.aw_addr, exp_law.pop_front());
          check("lite_aw_prot", 64'(lite_bus.aw_prot), 64'(exp_aw_prot));
        end
      end
      if (f_lw) begin
        if (exp_lw.size() == 0) fail_now("lite_w_unexpected");
        else begin
          wbeat_t e;
          e = exp_lw.pop_front();
          check("lite_w_data", lite_bus.w_data, e.data);
          check("lite_w_strb", 64'(lite_bus.w_strb), 64'(e.strb));
        end
      end
      if (f_lar) begin
        l_ar_addr = lite_bus.ar_addr;
        if (exp_lar.size() == 0) fail_now("lite_ar_unexpected");
        else begin
          check("lite_ar_addr", lite_bus.ar_addr, exp_lar.pop_front());
          check("lite_ar_prot", 64'(lite_bus.ar_prot), 64'(exp_ar_prot));
        end
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  function automatic bit all_idle();
    return aw_q.size() == 0 && w_q.size() == 0 && ar_q.size() == 0 && exp_b.size() == 0 &&
           exp_r.size() == 0 && exp_law.size() == 0 && exp_lw.size() == 0 &&
           exp_lar.size() == 0 && !slv_bus.aw_valid && !slv_bus.w_valid &&
           !slv_bus.ar_valid && !lite_bus.b_valid && !lite_bus.r_valid && !l_r_pend;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    for (int c = 0; c < budget; c++) begin
      if (all_idle()) return;
      wait_cycles(1);
    end
    fail_now({"timeout_", name});
  endtask

  task automatic issue(input vec_t v, input int k);
    if (v.is_wr) begin
      bexp_t be;
      aw_q.push_back(v);
      for (int i = 0; i <= int'(v.len); i++) begin
        wbeat_t wb;
        wb.data = 64'hA5 + (64'(i) << 8) + (64'(k) << 32);
        wb.strb = i[0] ? 8'h0F : 8'hFF;
        w_q.push_back(wb);
        if (!v.exp_err) begin
          exp_law.push_back(model_addr(v, i));
          exp_lw.push_back(wb);
          lite_bq.push_back(v.lite_b[2*i +: 2]);
        end
      end
      be.id = v.id;
      be.resp = v.exp_bresp;
      exp_b.push_back(be);
    end else begin
      ar_q.push_back(v);
      for (int i = 0; i <= int'(v.len); i++) begin
        rexp_t re;
        logic [63:0] a;
        re.id = v.id;
        re.last = (i == int'(v.len));
        if (v.exp_err) begin
          re.data = 64'd0;
          re.resp = 2'b10;
        end else begin
          a = model_addr(v, i);
          exp_lar.push_back(a);
          re.data = rdata_model(a);
          re.resp = {1'b0, a[3]};
        end
        exp_r.push_back(re);
      end
    end
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_slv_w_ready"}, 64'(slv_bus.w_ready), 64'd0);
    check({tag, "_slv_b_valid"}, 64'(slv_bus.b_valid), 64'd0);
    check({tag, "_slv_r_valid"}, 64'(slv_bus.r_valid), 64'd0);
    check({tag, "_lite_aw_valid"}, 64'(lite_bus.aw_valid), 64'd0);
    check({tag, "_lite_w_valid"}, 64'(lite_bus.w_valid), 64'd0);
    check({tag, "_lite_ar_valid"}, 64'(lite_bus.ar_valid), 64'd0);
    check({tag, "_lite_b_ready"}, 64'(lite_bus.b_ready), 64'd0);
    check({tag, "_lite_r_ready"}, 64'(lite_bus.r_ready), 64'd0);
  endtask

  vec_t vecs[10];
  vec_t rst_vec;

  initial begin
    vecs[0] = '{1, 4'd5, 64'h1000, 8'd0, 3'd3, 2'b01, 6'h00, 8'h00, 0, 2'b00};
    vecs[1] = '{0, 4'd2, 64'h2000, 8'd3, 3'd2, 2'b01, 6'h00, 8'h00, 0, 2'b00};
    vecs[2] = '{1, 4'd1, 64'h4000, 8'd2, 3'd3, 2'b01, 6'h00, 8'h0C, 0, 2'b11};
    vecs[3] = '{0, 4'd3, 64'h3018, 8'd3, 3'd3, 2'b10, 6'h00, 8'h00, !WrapEn, 2'b00};
    vecs[4] = '{1, 4'd7, 64'h5000, 8'd1, 3'd3, 2'b01, 6'h20, 8'h00, 1, 2'b10};
    vecs[5] = '{0, 4'd4, 64'h6000, 8'd1, 3'd4, 2'b01, 6'h00, 8'h00, 1, 2'b00};
    vecs[6] = '{1, 4'd2, 64'h7000, 8'd1, 3'd2, 2'b11, 6'h00, 8'h00, 1, 2'b10};
    vecs[7] = '{1, 4'd9, 64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 3'd3, 2'b01, 6'h00, 8'h04, 0, 2'b01};
    vecs[8] = '{0, 4'd6, 64'h8010, 8'd2, 3'd3, 2'b00, 6'h00, 8'h00, 0, 2'b00};
    vecs[9] = '{1, 4'd3, 64'h9008, 8'd1, 3'd2, 2'b10, 6'h00, 8'h00, !WrapEn,
                WrapEn ? 2'b00 : 2'b10};

    rst_n = 1'b0;
    wait_cycles(3);
    check("rst_slv_aw_ready", 64'(slv_bus.aw_ready), 64'd0);
    check("rst_slv_ar_ready", 64'(slv_bus.ar_ready), 64'd0);
    check_quiet_outputs("rst");
    rst_n = 1'b1;
    wait_cycles(1);
    check("idle_slv_aw_ready", 64'(slv_bus.aw_ready), 64'd1);
    check("idle_slv_ar_ready", 64'(slv_bus.ar_ready), 64'd1);

    for (int k = 0; k < 10; k++) begin
      issue(vecs[k], k);
      wait_idle($sformatf("vec%0d", k), 400);
    end

    // Stall Lite W, then reset while the write sits in the request state.
    stall_w = 1;
    rst_vec = '{1, 4'd8, 64'hA000, 8'd0, 3'd3, 2'b01, 6'h00, 8'h00, 0, 2'b00};
    issue(rst_vec, 12);
    wait_cycles(3);
    for (int c = 0; c < 5; c++) begin
      check("stall_lite_w_valid", 64'(lite_bus.w_valid), 64'd1);
      check("stall_lite_w_data", lite_bus.w_data, 64'hA5 + (64'd12 << 32));
      check("stall_slv_w_ready", 64'(slv_bus.w_ready), 64'd0);
      wait_cycles(1);
    end
    rst_n = 1'b0;
    aw_q.delete(); w_q.delete(); ar_q.delete(); exp_b.delete(); exp_r.delete();
    exp_law.delete(); exp_lw.delete(); exp_lar.delete(); lite_bq.delete();
    slv_bus.aw_valid = 0; slv_bus.w_valid = 0; slv_bus.ar_valid = 0;
    lite_bus.b_valid = 0; lite_bus.r_valid = 0;
    l_aw_got = 0; l_w_got = 0; l_r_pend = 0; stall_w = 0;
    wait_cycles(1);
    check("midrst_slv_aw_ready", 64'(slv_bus.aw_ready), 64'd0);
    check_quiet_outputs("midrst");
    rst_n = 1'b1;
    wait_cycles(1);
    check("postrst_slv_aw_ready", 64'(slv_bus.aw_ready), 64'd1);
    check_quiet_outputs("postrst");

    issue(vecs[0], 0);
    wait_idle("post_reset_write", 400);
    issue(vecs[1], 1);
    wait_idle("post_reset_read", 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
